// File: rtl/rx_frame_drainer_pkg.sv
// Shared definitions for the RX frame drainer: FSM state encoding, abort codes
// and the default frame start marker.
package rx_frame_drainer_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } drain_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_LEN      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hA5A5_5A5A;

    // A length field is usable when it is non-zero and fits the payload limit.
    function automatic logic len_in_range(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'({24'd0, len}) <= max_len);
    endfunction

endpackage

// File: rtl/rx_frame_drainer.sv
// Drains framed words (sync, length, payload, XOR trailer) from a FIFO read
// port and streams the payload downstream, flagging each frame good or aborted.
//
// state   | meaning
// --------+------------------------------------------------------------
// HUNT    | discard words until SYNC_WORD is read
// LEN     | next word's [7:0] is the payload count; validate it
// PAYLOAD | stream payload words out, XOR-accumulating the checksum
// CHECK   | compare the trailer word with the accumulated checksum
module rx_frame_drainer
    import rx_frame_drainer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MAX_LEN    = 16,
    parameter int                    TIMEOUT    = 1024,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = DATA_WIDTH'(SYNC_WORD_DEFAULT)
) (
    input  logic                  read_clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_rd_success,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [15:0]           drop_count,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT - 1);

    drain_state_t          state;
    drain_state_t          state_nxt;
    logic                  rd_pending;
    logic                  got;
    logic                  backpressure;
    logic                  tmo_running;
    logic                  tmo_expired;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [CNT_W-1:0]      words_left;
    logic [DATA_WIDTH-1:0] csum;
    logic                  abort;
    logic [1:0]            abort_code;
    logic                  frame_pass;
    logic                  rd_allowed;

    // An ack only counts if it answers a read we actually issued; this also
    // discards an ack still in flight when reset is released.
    assign got          = fifo_rd_success & rd_pending;
    assign backpressure = out_valid & ~out_ready;
    assign tmo_running  = (state != ST_HUNT) && !((state == ST_PAYLOAD) && backpressure);
    assign tmo_expired  = tmo_running && !got && (tmo_cnt == '0);

    always_ff @(posedge read_clk) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        abort      = 1'b0;
        abort_code = ERR_NONE;
        frame_pass = 1'b0;
        unique case (state)
            ST_HUNT: begin
                if (got && (fifo_data == SYNC_WORD)) begin
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (got) begin
                    if (len_in_range(fifo_data[7:0], MAX_LEN)) begin
                        state_nxt = ST_PAYLOAD;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_LEN;
                    end
                end else if (tmo_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            ST_PAYLOAD: begin
                if (out_valid && out_ready && out_last) begin
                    state_nxt = ST_CHECK;
                end else if (tmo_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (got) begin
                    if (fifo_data == csum) begin
                        frame_pass = 1'b1;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_CHECKSUM;
                    end
                    state_nxt = ST_HUNT;
                end else if (tmo_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
        if (abort) begin
            state_nxt = ST_HUNT;
        end
    end

    // Payload reads stop once every word of the frame has been fetched, so
    // the trailer is only read after the final word has been handed off.
    always_comb begin
        busy       = (state != ST_HUNT);
        rd_allowed = 1'b1;
        if (state == ST_PAYLOAD) begin
            rd_allowed = (words_left != '0) && !backpressure;
        end
        fifo_rd_en = !rst && !fifo_empty && !rd_pending && rd_allowed && !abort;
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
            drop_count <= 16'd0;
            tmo_cnt    <= '0;
            words_left <= '0;
            csum       <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            rd_pending <= fifo_rd_en;
            frame_ok   <= frame_pass;
            frame_err  <= abort;
            if (abort) begin
                err_code <= abort_code;
            end

            if ((state == ST_HUNT) && got && (fifo_data != SYNC_WORD) && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end

            if (got || (state == ST_HUNT)) begin
                tmo_cnt <= TMO_RELOAD;
            end else if (tmo_running && (tmo_cnt != '0)) begin
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            end

            if ((state == ST_LEN) && (state_nxt == ST_PAYLOAD)) begin
                words_left <= CNT_W'(fifo_data[7:0]);
            end else if ((state == ST_PAYLOAD) && got) begin
                words_left <= words_left - CNT_W'(1);
            end

            if (state_nxt == ST_HUNT) begin
                csum <= '0;
            end else if ((state == ST_PAYLOAD) && got) begin
                csum <= csum ^ fifo_data;
            end

            // A word already on the output is never withdrawn, even on abort.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if ((state == ST_PAYLOAD) && got) begin
                out_data  <= fifo_data;
                out_valid <= 1'b1;
                out_last  <= (words_left == CNT_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_drainer.sv
// Randomised self-checking bench for rx_frame_drainer: a FIFO model with stale
// empty and failed reads, and a stream-level frame parser as the reference.
`timescale 1ns/1ps
module tb_rx_frame_drainer;

    localparam int          DW      = 32;
    localparam int          MAX_LEN = 16;
    localparam int          TIMEOUT = 1024;
    localparam logic [31:0] SYNC    = 32'hA5A5_5A5A;

    logic          read_clk;
    logic          rst;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_success;
    logic          fifo_empty;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_ok;
    logic          frame_err;
    logic [1:0]    err_code;
    logic [15:0]   drop_count;
    logic          busy;

    rx_frame_drainer #(
        .DATA_WIDTH (DW),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT    (TIMEOUT),
        .SYNC_WORD  (SYNC)
    ) dut (
        .read_clk        (read_clk),
        .rst             (rst),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_data       (fifo_data),
        .fifo_rd_success (fifo_rd_success),
        .fifo_empty      (fifo_empty),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .frame_ok        (frame_ok),
        .frame_err       (frame_err),
        .err_code        (err_code),
        .drop_count      (drop_count),
        .busy            (busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] stim[$];
    logic [31:0] fifo_q[$];
    logic [32:0] exp_out[$];
    int          exp_res[$];
    int          exp_drops = 0;
    int          fail_pct = 0;
    int          ready_pct = 100;
    bit          rst_drv = 1'b1;
    bit          rd_req_prev = 1'b0;
    bit          empty_reg = 1'b1;
    bit          inject_ack = 1'b0;
    bit          hold_valid = 1'b0;
    logic [32:0] hold_word = '0;
    int          cyc = 0;
    int          last_succ_cyc = 0;
    int          err_pulses = 0;

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // One clock cycle: drive FIFO/consumer inputs at negedge, then score outputs.
    task automatic tick();
        int code;
        @(negedge read_clk);
        cyc++;
        rst             = rst_drv;
        fifo_rd_success = 1'b0;
        fifo_data       = $urandom;
        if (inject_ack) begin
            fifo_rd_success = 1'b1;
            fifo_data       = SYNC;
            inject_ack      = 1'b0;
        end else if (rd_req_prev && fifo_q.size() > 0 && $urandom_range(99) >= fail_pct) begin
            fifo_rd_success = 1'b1;
            fifo_data       = fifo_q.pop_front();
            last_succ_cyc   = cyc;
        end
        fifo_empty = empty_reg;
        out_ready  = ($urandom_range(99) < ready_pct);
        #1;
        if (rst) begin
            check("rst_rd_en", fifo_rd_en, 0);
            check("rst_frame_err", frame_err, 0);
            hold_valid = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                check("rd_en_while_empty", fifo_empty, 0);
                check("rd_en_while_pending", rd_req_prev, 0);
            end
            if (hold_valid) begin
                check("out_hold_valid", out_valid, 1);
                if (out_valid) check("out_hold_word", {out_last, out_data}, hold_word);
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) check("out_unexpected", out_valid, 0);
                else check("out_word", {out_last, out_data}, exp_out.pop_front());
            end
            hold_valid = out_valid && !out_ready;
            hold_word  = {out_last, out_data};
            if (frame_ok || frame_err) begin
                code = frame_ok ? 0 : int'(err_code);
                if (frame_ok && frame_err) code = 9;
                if (exp_res.size() == 0) check("result_unexpected", frame_ok | frame_err, 0);
                else check("frame_result", code, exp_res.pop_front());
                if (frame_err) err_pulses++;
                if (frame_err && err_code == 2'd2)
                    check("tmo_latency", (cyc - last_succ_cyc >= TIMEOUT) && (cyc - last_succ_cyc <= TIMEOUT + 2), 1);
            end
        end
        rd_req_prev = fifo_rd_en && !rst;
        empty_reg   = (fifo_q.size() == 0) && !(fail_pct > 0 && $urandom_range(3) == 0);
    endtask

    task automatic do_reset(input bit stale_ack);
        rst_drv = 1'b1;
        fifo_q.delete();
        exp_out.delete();
        exp_res.delete();
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_busy", busy, 0);
        check("rst_err_code", err_code, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_out_data", out_data, 0);
        exp_drops  = 0;
        rst_drv    = 1'b0;
        inject_ack = stale_ack;
    endtask

    // Reference: parse the word stream with the frame rules.
    task automatic load_stream();
        int          i;
        int          len;
        logic [31:0] w;
        logic [31:0] x;
        i = 0;
        while (i < stim.size()) begin
            w = stim[i];
            i++;
            if (w != SYNC) begin
                exp_drops++;
                continue;
            end
            if (i >= stim.size()) break;
            len = int'(stim[i][7:0]);
            i++;
            if (len == 0 || len > MAX_LEN) begin
                exp_res.push_back(1);
                continue;
            end
            x = '0;
            for (int k = 0; k < len && i < stim.size(); k++) begin
                x = x ^ stim[i];
                exp_out.push_back({k == len - 1, stim[i]});
                i++;
            end
            if (i < stim.size()) begin
                exp_res.push_back((stim[i] == x) ? 0 : 3);
                i++;
            end
        end
        foreach (stim[j]) fifo_q.push_back(stim[j]);
        stim.delete();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || exp_out.size() > 0 || exp_res.size() > 0 || busy || out_valid) && n < bound) begin
            tick();
            n++;
        end
        check("drain_in_time", n < bound, 1);
        repeat (4) tick();
        check("drop_count", drop_count, exp_drops);
        check("out_left", exp_out.size(), 0);
        check("res_left", exp_res.size(), 0);
    endtask

    task automatic push_frame(input logic [31:0] trailer);
        stim.push_back(SYNC);
        stim.push_back(32'd3);
        stim.push_back(32'h11);
        stim.push_back(32'h22);
        stim.push_back(32'h44);
        stim.push_back(trailer);
    endtask

    task automatic gen_random(input int nframes);
        int          nj;
        int          kind;
        int          len;
        logic [31:0] w;
        logic [31:0] x;
        for (int f = 0; f < nframes; f++) begin
            nj = $urandom_range(2);
            for (int j = 0; j < nj; j++) begin
                w = $urandom;
                if (w == SYNC) w = ~w;
                stim.push_back(w);
            end
            stim.push_back(SYNC);
            kind = $urandom_range(9);
            w = $urandom;
            if (kind == 0) begin
                len = ($urandom_range(1) == 0) ? 0 : $urandom_range(255, MAX_LEN + 1);
                w[7:0] = 8'(len);
                stim.push_back(w);
            end else begin
                len = $urandom_range(MAX_LEN, 1);
                w[7:0] = 8'(len);
                stim.push_back(w);
                x = '0;
                for (int k = 0; k < len; k++) begin
                    w = ($urandom_range(9) == 0) ? SYNC : $urandom;
                    x = x ^ w;
                    stim.push_back(w);
                end
                if (kind == 1) x = x ^ (32'd1 << $urandom_range(31));
                stim.push_back(x);
            end
        end
    endtask

    initial begin
        int          n;
        int          e0;
        logic [31:0] w1;
        logic [31:0] w2;
        rst             = 1'b1;
        fifo_data       = '0;
        fifo_rd_success = 1'b0;
        fifo_empty      = 1'b1;
        out_ready       = 1'b1;

        // good frame
        do_reset(0);
        push_frame(32'h77);
        load_stream();
        drain(500);
        check("good_err_code", err_code, 0);

        // junk words ahead of the good frame
        do_reset(0);
        for (int j = 1; j <= 5; j++) stim.push_back(32'h1000 + 32'(j));
        push_frame(32'h77);
        load_stream();
        drain(500);
        check("junk_drop5", drop_count, 5);

        // bad lengths, then a clean frame
        do_reset(0);
        stim.push_back(SYNC);
        stim.push_back(32'd0);
        stim.push_back(SYNC);
        stim.push_back(32'd17);
        push_frame(32'h77);
        load_stream();
        drain(500);
        check("badlen_err_held", err_code, 1);

        // checksum error
        do_reset(0);
        push_frame(32'h78);
        load_stream();
        drain(500);
        check("csum_err_code", err_code, 3);

        // long backpressure, then FIFO starvation mid-payload
        do_reset(0);
        w1 = 32'hDEAD_0001;
        w2 = 32'hDEAD_0002;
        stim.push_back(SYNC);
        stim.push_back(32'd4);
        stim.push_back(w1);
        stim.push_back(w2);
        load_stream();
        exp_res.push_back(2);
        ready_pct = 0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_first_valid", out_valid, 1);
        e0 = err_pulses;
        repeat (2000) tick();
        check("bp_no_abort", err_pulses - e0, 0);
        check("bp_held_data", out_data, w1);
        check("bp_busy", busy, 1);
        ready_pct = 100;
        drain(3000);
        check("tmo_err_code", err_code, 2);

        // reset mid-frame with a stale ack on release
        do_reset(0);
        stim.push_back(SYNC);
        stim.push_back(32'd6);
        stim.push_back(32'h0A);
        stim.push_back(32'h0B);
        stim.push_back(32'h0C);
        load_stream();
        n = 0;
        while (exp_out.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("midrst_busy_before", busy, 1);
        e0 = err_pulses;
        do_reset(1);
        repeat (3) tick();
        check("midrst_no_err", err_pulses - e0, 0);
        check("midrst_ignore_ack", busy, 0);
        check("midrst_drops", drop_count, 0);
        push_frame(32'h77);
        load_stream();
        drain(500);

        // random frames with failed reads, stale empty and random backpressure
        for (int r = 0; r < 3; r++) begin
            do_reset(0);
            fail_pct  = 25;
            ready_pct = 40 + 20 * r;
            gen_random(30);
            load_stream();
            drain(20000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
